// File: rtl/data_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : data_mem_responder
// Brief    : Single-outstanding memory responder with fixed request-to-response
//            latency, synchronous-write / registered-read word storage.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DW      = 32,
   parameter int AW      = 8,
   parameter int LATENCY = 2
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          ReqValid,
   output logic          ReqReady,
   input  logic          ReqWE,
   input  logic [DW-1:0] ReqAddr,
   input  logic [DW-1:0] ReqWData,
   output logic          RespValid,
   input  logic          RespReady,
   output logic [DW-1:0] RespRData,
   output logic          Busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt_nxt;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_mem [2**AW];

   logic          w_accept;
   logic          w_enter_resp;
   logic          w_tgt_we;
   logic [AW-1:0] w_tgt_addr;
   logic [DW-1:0] w_tgt_wdata;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      ReqReady     = 1'b0;
      RespValid    = 1'b0;
      w_accept     = 1'b0;
      w_enter_resp = 1'b0;
      case (r_state)
         IDLE: begin
            ReqReady = 1'b1;
            if (ReqValid) begin
               w_accept = 1'b1;
               if (LATENCY == 1) begin
                  w_state_nxt  = RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = c_cnt_load;
               end
            end
         end
         WAIT: begin
            // Leave on the edge that brings the counter to zero, so the
            // response shows up exactly LATENCY cycles after acceptance.
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_state_nxt  = RESP;
               w_enter_resp = 1'b1;
               w_cnt_nxt    = 4'd0;
            end
         end
         RESP: begin
            RespValid = 1'b1;
            if (RespReady) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign Busy = (r_state != IDLE);

   // With LATENCY=1 the response is formed straight from the request inputs.
   assign w_tgt_we    = (r_state == IDLE) ? ReqWE            : r_we;
   assign w_tgt_addr  = (r_state == IDLE) ? ReqAddr[AW-1:0]  : r_addr;
   assign w_tgt_wdata = (r_state == IDLE) ? ReqWData         : r_wdata;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         RespRData <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_we    <= ReqWE;
            r_addr  <= ReqAddr[AW-1:0];
            r_wdata <= ReqWData;
         end
         if (w_enter_resp) begin
            RespRData <= w_tgt_we ? w_tgt_wdata : r_mem[w_tgt_addr];
         end
      end
   end

   // Storage is deliberately outside the reset domain: contents survive reset.
   always_ff @(posedge Clk) begin
      if (w_enter_resp && w_tgt_we) begin
         r_mem[w_tgt_addr] <= w_tgt_wdata;
      end
   end

   generate
      if (DW > AW) begin : g_unused_addr
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = |ReqAddr[DW-1:AW];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : tb_data_mem_responder
// Brief    : Scoreboard bench for data_mem_responder at LATENCY 2, 1 and 4.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int n_done = 0;

   task automatic chk(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s (lat=%0d): actual %h required %h", name, lat, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

      logic        rst = 1'b1;
      logic        req_valid = 1'b0;
      logic        req_ready;
      logic        req_we = 1'b0;
      logic [31:0] req_addr = '0;
      logic [31:0] req_wdata = '0;
      logic        resp_valid;
      logic        resp_ready = 1'b0;
      logic [31:0] resp_rdata;
      logic        busy;
      bit          hold_rdy = 1'b0;
      int          cyc = 0;

      // Reference: plain word array with sequential semantics, plus the
      // expected response data and acceptance cycle of each request.
      logic [31:0] model [256];
      logic [31:0] exp_data_q [$];
      int          exp_cyc_q [$];

      data_mem_responder #(
         .DW      (32),
         .AW      (8),
         .LATENCY (LAT)
      ) u_dut (
         .Clk       (clk),
         .Rst       (rst),
         .ReqValid  (req_valid),
         .ReqReady  (req_ready),
         .ReqWE     (req_we),
         .ReqAddr   (req_addr),
         .ReqWData  (req_wdata),
         .RespValid (resp_valid),
         .RespReady (resp_ready),
         .RespRData (resp_rdata),
         .Busy      (busy)
      );

      always @(posedge clk) cyc <= cyc + 1;

      initial begin
         forever begin
            @(posedge clk);
            #1;
            resp_ready = !hold_rdy && ($urandom_range(3, 0) != 0);
         end
      end

      // Monitor: pops one expectation per new response, checks data and latency.
      initial begin
         bit          in_resp;
         logic [31:0] held;
         in_resp = 1'b0;
         held    = '0;
         forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
               chk("reqready_low_in_resp", LAT, 32'(req_ready), 32'd0);
               if (!in_resp) begin
                  chk("resp_expected", LAT, 32'(exp_data_q.size() != 0), 32'd1);
                  if (exp_data_q.size() != 0) begin
                     chk("resp_data", LAT, resp_rdata, exp_data_q.pop_front());
                     chk("resp_latency", LAT, cyc - exp_cyc_q.pop_front() + 1, LAT);
                  end
                  held = resp_rdata;
               end else begin
                  chk("resp_data_hold", LAT, resp_rdata, held);
               end
               in_resp = (resp_ready !== 1'b1);
            end else begin
               in_resp = 1'b0;
            end
         end
      end

      task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] data);
         int n;
         n = 0;
         while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("ready_wait_bounded", LAT, 32'(n < 200), 32'd1);
         req_valid = 1'b1;
         req_we    = we;
         req_addr  = addr;
         req_wdata = data;
         @(posedge clk);
         #1;
         exp_data_q.push_back(we ? data : model[addr[7:0]]);
         exp_cyc_q.push_back(cyc);
         if (we) model[addr[7:0]] = data;
         chk("busy_after_accept", LAT, 32'(busy), 32'd1);
         // Requests presented while busy must be ignored.
         n = 0;
         while (busy === 1'b1 && n < 200) begin
            req_valid = 1'($urandom_range(1, 0));
            req_we    = 1'($urandom_range(1, 0));
            req_addr  = $urandom;
            req_wdata = $urandom;
            @(posedge clk);
            #1;
            n++;
         end
         req_valid = 1'b0;
         chk("resp_done_bounded", LAT, 32'(n < 200), 32'd1);
      endtask

      task automatic reset_checks();
         chk("rst_reqready", LAT, 32'(req_ready), 32'd1);
         chk("rst_respvalid", LAT, 32'(resp_valid), 32'd0);
         chk("rst_resprdata", LAT, resp_rdata, 32'd0);
         chk("rst_busy", LAT, 32'(busy), 32'd0);
      endtask

      initial begin
         int          d;
         int          n;
         logic [31:0] wd;
         repeat (3) @(posedge clk);
         #1;
         reset_checks();
         @(negedge clk);
         rst = 1'b0;

         for (int a = 0; a < 256; a++) begin
            issue(1'b1, 32'(a), $urandom);
         end

         issue(1'b1, 32'd5, 32'hDEADBEEF);
         issue(1'b0, 32'd5, 32'h0);
         issue(1'b1, 32'h100, 32'h12345678);
         issue(1'b0, 32'h0, 32'h0);

         // Backpressure: the response must hold while RespReady stays low.
         hold_rdy = 1'b1;
         fork
            issue(1'b0, 32'd5, 32'h0);
            begin
               n = 0;
               while (resp_valid !== 1'b1 && n < 50) begin
                  @(negedge clk);
                  n++;
               end
               chk("bp_resp_seen", LAT, 32'(n < 50), 32'd1);
               repeat (4) begin
                  @(negedge clk);
                  chk("bp_valid_held", LAT, 32'(resp_valid), 32'd1);
               end
               hold_rdy = 1'b0;
            end
         join

         // Reset while the write is in flight; a write reaching RESP is committed.
         for (int k = 0; k < 2; k++) begin
            d  = (k == 0) ? 0 : $urandom_range(LAT - 1, 0);
            wd = (k == 0) ? 32'hAAAA5555 : $urandom;
            chk("idle_before_rst_test", LAT, 32'(req_ready), 32'd1);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'd3;
            req_wdata = wd;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            repeat (d) begin
               @(posedge clk);
               #1;
            end
            rst = 1'b1;
            #1;
            reset_checks();
            if (d >= LAT - 1) model[3] = wd;
            @(negedge clk);
            rst = 1'b0;
            issue(1'b0, 32'd3, 32'h0);
         end

         for (int i = 0; i < 150; i++) begin
            issue(1'($urandom_range(1, 0)), $urandom, $urandom);
         end

         repeat (4) @(posedge clk);
         #1;
         chk("scoreboard_drained", LAT, 32'(exp_data_q.size()), 32'd0);
         n_done++;
      end
   end

   initial begin
      fork
         wait (n_done == 3);
         #2000000;
      join_any
      chk("all_instances_done", 0, 32'(n_done), 32'd3);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DW, default 32, data and address word width.
REQ-002 SHALL have parameter AW, default 8, word-index bits, giving a storage depth of 2^AW words.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 SHALL have port Clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port Rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port ReqValid, input, 1, initiator presents a request.
REQ-007 SHALL have port ReqReady, output, 1, responder can accept a request.
REQ-008 SHALL have port ReqWE, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port ReqAddr, input, DW, word address; low AW bits used.
REQ-010 SHALL have port ReqWData, input, DW, write data.
REQ-011 SHALL have port RespValid, output, 1, response available.
REQ-012 SHALL have port RespReady, input, 1, initiator accepts the response.
REQ-013 SHALL have port RespRData, output, DW, read data, or the write-data echo for writes.
REQ-014 SHALL have port Busy, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive ReqReady=1 only in IDLE; ReqReady SHALL be combinational on state only and never depend on ReqValid.
REQ-017 SHALL accept a request on an edge where ReqValid=1 and ReqReady=1, latching ReqWE, ReqAddr[AW-1:0] and ReqWData.
REQ-018 SHALL ignore ReqAddr bits above AW-1 (address wrap-around), so address 2^AW aliases address 0.
REQ-019 SHALL load a latency counter with LATENCY-1 on acceptance and go IDLE->WAIT; if LATENCY=1, SHALL go IDLE->RESP directly.
REQ-020 SHALL decrement the counter once per cycle in WAIT and go WAIT->RESP on the edge where the counter equals 0.
REQ-021 SHALL assert RespValid in RESP only, exactly LATENCY cycles after the accepting edge.
REQ-022 SHALL, for reads, register memory[addr] into RespRData on the edge entering RESP.
REQ-023 SHALL, for writes, commit ReqWData to memory[addr] on the edge entering RESP and set RespRData = written data.
REQ-024 SHALL hold RespValid and RespRData stable in RESP until an edge with RespReady=1, then return to IDLE.
REQ-025 SHALL NOT accept a new request in the same cycle RESP completes; minimum request spacing is LATENCY+1 cycles.
REQ-026 SHALL give a read to an address written by the immediately preceding request the new value (read-after-write).
REQ-027 SHALL ignore ReqValid, ReqWE, ReqAddr and ReqWData outside IDLE.
REQ-028 SHALL ignore RespReady outside RESP.
REQ-029 SHALL use synchronous-write, registered-read storage of 2^AW x DW words.

Reset
REQ-030 SHALL, while Rst=1, force state IDLE, ReqReady=1, RespValid=0, RespRData=0, Busy=0, counter=0.
REQ-031 SHALL NOT clear memory contents on reset.
REQ-032 SHALL drop a write that is in WAIT when Rst asserts; memory is unmodified.
REQ-033 SHALL accept a request on the first rising edge after Rst deasserts.

Verification
REQ-034 SHALL verify write then read: write addr 5 data 0xDEADBEEF, then read addr 5 -> RespValid exactly 2 cycles after each accept; read RespRData=0xDEADBEEF.
REQ-035 SHALL verify backpressure: hold RespReady=0 for 4 cycles in RESP -> RespValid and RespRData stay constant and ReqReady stays 0; complete on the RespReady=1 edge.
REQ-036 SHALL verify aliasing: write addr 0x100 data 0x12345678 with AW=8, then read addr 0 -> 0x12345678.
REQ-037 SHALL verify reset mid-write: write addr 3 data 0xAAAA5555, assert Rst in WAIT -> outputs go to reset values immediately; a later read of addr 3 returns the prior content.
REQ-038 SHALL verify LATENCY=1 and LATENCY=4 builds: RespValid rises 1 and 4 cycles after accept respectively, with no WAIT state used when LATENCY=1.
REQ-039 SHALL verify that ignored requests cause no effect: toggle ReqValid/ReqAddr during WAIT -> no extra response and no memory change.
